apb_master_bridge: RTL and testbench

- Synthesizable APB3/APB4 requester that turns a valid/ready request channel into APB SETUP/ACCESS transfers and returns a valid/ready response.
- Sits directly upstream of the APB slaves that the global package describes, and drives the same signals: pselx, penable, pwrite, paddr, pwdata, pstrb, pprot, pready, prdata, pslverr.
- Decodes the address to a one-hot pselx encoded as slave_no_e (bit0 = SLAVE_1).
- Enforces a wait-state timeout so that a hung slave cannot stall the bus.

---
 rtl/apb_master_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_apb_master_bridge.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB3/APB4 requester: converts a valid/ready request into one APB SETUP/ACCESS transfer
// and returns the outcome (data, slave error, timeout or decode error) on a valid/ready response.
`timescale 1ns/1ps
module apb_master_bridge #(
  parameter int unsigned NO_OF_SLAVES    = 1,
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned SLAVE_SPAN_LOG2 = 12,
  parameter int unsigned TIMEOUT_CYCLES  = 16
) (
  input  logic                       pclk,
  input  logic                       preset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [ADDRESS_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]      req_wdata,
  input  logic [DATA_WIDTH/8-1:0]    req_strb,
  input  logic [2:0]                 req_prot,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic                       rsp_slverr,
  output logic                       rsp_timeout,
  output logic                       rsp_decerr,
  output logic [NO_OF_SLAVES-1:0]    pselx,
  output logic                       penable,
  output logic                       pwrite,
  output logic [ADDRESS_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]      pwdata,
  output logic [DATA_WIDTH/8-1:0]    pstrb,
  output logic [2:0]                 pprot,
  input  logic                       pready,
  input  logic [DATA_WIDTH-1:0]      prdata,
  input  logic                       pslverr
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Counter value on the last tolerated wait edge; one more pready=0 edge aborts.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]               r_state;
  logic [1:0]               w_state_next;
  logic                     r_req_ready;
  logic [7:0]               r_wait_cnt;

  logic [NO_OF_SLAVES-1:0]  r_pselx;
  logic                     r_penable;
  logic                     r_pwrite;
  logic [ADDRESS_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0]    r_pwdata;
  logic [STRB_WIDTH-1:0]    r_pstrb;
  logic [2:0]               r_pprot;

  logic                     r_rsp_valid;
  logic [DATA_WIDTH-1:0]    r_rsp_rdata;
  logic                     r_rsp_slverr;
  logic                     r_rsp_timeout;
  logic                     r_rsp_decerr;

  logic                     w_accept;
  logic                     w_dec_ok;
  logic                     w_done;
  logic                     w_expire;
  logic                     w_rsp_fire;
  logic [ADDRESS_WIDTH-1:0] w_index;
  logic [NO_OF_SLAVES-1:0]  w_sel;

  // req_ready is registered and only high in IDLE, so it doubles as the IDLE qualifier.
  assign w_accept   = req_valid & r_req_ready;
  assign w_index    = req_addr >> SLAVE_SPAN_LOG2;
  assign w_dec_ok   = (w_index < ADDRESS_WIDTH'(NO_OF_SLAVES));
  assign w_done     = (r_state == ST_ACCESS) & pready;
  assign w_expire   = (r_state == ST_ACCESS) & ~pready & (r_wait_cnt == WAIT_LAST);
  assign w_rsp_fire = r_rsp_valid & rsp_ready;

  always_comb begin
    w_sel = '0;
    for (int unsigned k = 0; k < NO_OF_SLAVES; k++) begin
      w_sel[k] = (w_index == ADDRESS_WIDTH'(k));
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = w_dec_ok ? ST_SETUP : ST_RESP;
        end
      end
      ST_SETUP:  w_state_next = ST_ACCESS;
      ST_ACCESS: begin
        if (w_done || w_expire) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (w_rsp_fire) begin
          w_state_next = ST_IDLE;
        end
      end
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b0;
      r_wait_cnt  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_req_ready <= (w_state_next == ST_IDLE);
      if (r_state != ST_ACCESS) begin
        r_wait_cnt <= '0;
      end else if (!pready) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
    end
  end

  // APB outputs keep their last values between transfers; only pselx/penable return to 0.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_pselx   <= '0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_pprot   <= '0;
    end else begin
      if (w_accept && w_dec_ok) begin
        r_pselx  <= w_sel;
        r_pwrite <= req_write;
        r_paddr  <= req_addr;
        r_pwdata <= req_write ? req_wdata : '0;
        r_pstrb  <= req_write ? req_strb : '0;
        r_pprot  <= req_prot;
      end else if (w_done || w_expire) begin
        r_pselx <= '0;
      end
      if (r_state == ST_SETUP) begin
        r_penable <= 1'b1;
      end else if (w_done || w_expire) begin
        r_penable <= 1'b0;
      end
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_slverr  <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_decerr  <= 1'b0;
    end else if (w_accept && !w_dec_ok) begin
      r_rsp_valid   <= 1'b1;
      r_rsp_rdata   <= '0;
      r_rsp_slverr  <= 1'b1;
      r_rsp_timeout <= 1'b0;
      r_rsp_decerr  <= 1'b1;
    end else if (w_done) begin
      r_rsp_valid   <= 1'b1;
      r_rsp_rdata   <= r_pwrite ? '0 : prdata;
      r_rsp_slverr  <= pslverr;
      r_rsp_timeout <= 1'b0;
      r_rsp_decerr  <= 1'b0;
    end else if (w_expire) begin
      r_rsp_valid   <= 1'b1;
      r_rsp_rdata   <= '0;
      r_rsp_slverr  <= 1'b1;
      r_rsp_timeout <= 1'b1;
      r_rsp_decerr  <= 1'b0;
    end else if (w_rsp_fire) begin
      r_rsp_valid   <= 1'b0;
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_slverr  = r_rsp_slverr;
  assign rsp_timeout = r_rsp_timeout;
  assign rsp_decerr  = r_rsp_decerr;
  assign pselx       = r_pselx;
  assign penable     = r_penable;
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign pstrb       = r_pstrb;
  assign pprot       = r_pprot;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: the bench plays the APB slave and the request/response
// endpoints, predicting every cycle from address decode, wait count and timeout rules.
`timescale 1ns/1ps
module tb_apb_master_bridge;

  localparam int unsigned NSLV = 4;
  localparam int unsigned SPAN = 12;
  localparam int unsigned TMO  = 4;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic [2:0]  req_prot;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr, rsp_timeout, rsp_decerr;
  logic [3:0]  pselx;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_addr = 32'h0;

  always #5 pclk = ~pclk;

  apb_master_bridge #(
    .NO_OF_SLAVES(NSLV), .ADDRESS_WIDTH(32), .DATA_WIDTH(32),
    .SLAVE_SPAN_LOG2(SPAN), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout), .rsp_decerr(rsp_decerr),
    .pselx(pselx), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .pprot(pprot), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  // Entered and left just after a falling edge. waits = pready=0 cycles before the slave
  // answers; waits >= TMO means the slave never answers in time.
  task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot, input int waits,
                          input logic err, input logic [31:0] rdata, input int hold,
                          input string name);
    int          idx;
    bit          dec_ok;
    int          acc;
    int          resp_k;
    logic [3:0]  exp_sel;
    logic [76:0] exp_bus;
    logic [36:0] exp_rsp;
    logic [36:0] got_rsp;
    idx     = int'(addr >> SPAN);
    dec_ok  = (idx < int'(NSLV));
    exp_sel = dec_ok ? 4'(32'd1 << idx) : 4'd0;
    acc     = (waits < int'(TMO)) ? waits + 1 : int'(TMO);
    resp_k  = dec_ok ? 2 + acc : 1;
    if (!dec_ok)               exp_rsp = {1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    else if (waits >= int'(TMO)) exp_rsp = {1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    else                       exp_rsp = {1'b1, (wr ? 32'h0 : rdata), err, 1'b0, 1'b0, 1'b0};

    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s idle_ready: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    req_strb = strb; req_prot = prot; rsp_ready = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    if (dec_ok) last_addr = addr;
    exp_bus = {exp_sel, 1'b0, wr, addr, (wr ? wdata : 32'h0), (wr ? strb : 4'h0), prot};

    for (int k = 1; k < resp_k; k++) begin
      pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
      if (k == 1) begin
        pready = 1'($urandom_range(0, 1));
        n_vec++;
        if ({pselx, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid, req_ready}
            !== {exp_bus, 2'b00}) begin
          n_err++;
          $display("FAIL %s setup: got %h want %h", name,
                   {pselx, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid, req_ready},
                   {exp_bus, 2'b00});
        end
      end else begin
        exp_bus[72] = 1'b1;
        if (k - 2 == waits) begin
          pready = 1'b1; prdata = rdata; pslverr = err;
        end
        n_vec++;
        if ({pselx, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid, req_ready}
            !== {exp_bus, 2'b00}) begin
          n_err++;
          $display("FAIL %s access%0d: got %h want %h", name, k - 2,
                   {pselx, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid, req_ready},
                   {exp_bus, 2'b00});
        end
      end
      @(negedge pclk);
    end
    pready = 1'b0;

    n_vec++;
    if ({pselx, penable, paddr} !== {4'h0, 1'b0, last_addr}) begin
      n_err++;
      $display("FAIL %s resp_bus: got %h want %h", name, {pselx, penable, paddr},
               {4'h0, 1'b0, last_addr});
    end
    for (int h = 0; h <= hold; h++) begin
      got_rsp = {rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, rsp_decerr, req_ready};
      n_vec++;
      if (got_rsp !== exp_rsp) begin
        n_err++;
        $display("FAIL %s resp%0d: got %h want %h", name, h, got_rsp, exp_rsp);
      end
      if (h == hold) rsp_ready = 1'b1;
      @(negedge pclk);
    end
    rsp_ready = 1'b0;
    n_vec++;
    if ({rsp_valid, req_ready, pselx, penable} !== {1'b0, 1'b1, 4'h0, 1'b0}) begin
      n_err++;
      $display("FAIL %s after_hs: got %b want %b", name, {rsp_valid, req_ready, pselx, penable},
               {1'b0, 1'b1, 4'h0, 1'b0});
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge pclk);
    n_vec++;
    if ({pselx, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid, rsp_rdata,
         rsp_slverr, rsp_timeout, rsp_decerr, req_ready} !== 113'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", {pselx, penable, pwrite, paddr, pwdata,
               pstrb, pprot, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, rsp_decerr,
               req_ready});
    end
    preset = 1'b0;
    #1;
    n_vec++;
    if (req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_ready: got %b want 0", req_ready);
    end
    @(negedge pclk);
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_first_edge_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_write_nowait();
    run_xfer(32'h0000_0010, 1'b1, 32'hA5A5_1234, 4'hF, 3'b010, 0, 1'b0, 32'h0, 0, "wr_nowait");
  endtask

  task automatic test_read_wait();
    run_xfer(32'h0000_2004, 1'b0, 32'h1357_9BDF, 4'hA, 3'b001, 3, 1'b0, 32'hDEAD_BEEF, 0,
             "rd_wait3");
  endtask

  task automatic test_slverr();
    run_xfer(32'h0000_1008, 1'b1, 32'h0BAD_F00D, 4'h3, 3'b100, 1, 1'b1, 32'h0, 0, "slverr");
  endtask

  task automatic test_decerr();
    run_xfer(32'h0000_4000, 1'b1, 32'h1111_2222, 4'hF, 3'b000, 0, 1'b0, 32'h0, 0, "decerr");
  endtask

  task automatic test_timeout_backpressure();
    run_xfer(32'h0000_3010, 1'b0, 32'h0, 4'hF, 3'b011, 1000, 1'b0, 32'hCAFE_0001, 5,
             "timeout");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    for (int t = 0; t < 40; t++) begin
      a = (32'($urandom_range(0, NSLV)) << SPAN) | (32'($urandom_range(0, 1023)) << 2);
      run_xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), 3'($urandom),
               int'($urandom_range(0, TMO + 1)), 1'($urandom_range(0, 1)), $urandom,
               int'($urandom_range(0, 2)), "b2b");
    end
  endtask

  task automatic test_reset_mid_access();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_3000; req_prot = 3'b111;
    pready = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    req_valid = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    n_vec++;
    if ({pselx, penable} !== 5'b1000_1) begin
      n_err++;
      $display("FAIL rst_mid_wait2: got %b want 10001", {pselx, penable});
    end
    #2 preset = 1'b1;
    #1;
    n_vec++;
    if ({pselx, penable, rsp_valid, req_ready, paddr} !== 39'h0) begin
      n_err++;
      $display("FAIL rst_mid_async: got %h want 0", {pselx, penable, rsp_valid, req_ready, paddr});
    end
    @(negedge pclk);
    preset = 1'b0;
    last_addr = 32'h0;
    #1;
    n_vec++;
    if (req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_release: got %b want 0", req_ready);
    end
    @(negedge pclk);
    n_vec++;
    if ({req_ready, rsp_valid, pselx, penable} !== 7'b10_0000_0) begin
      n_err++;
      $display("FAIL rst_mid_recover: got %b want 1000000", {req_ready, rsp_valid, pselx, penable});
    end
    run_xfer(32'h0000_1100, 1'b1, 32'h7777_8888, 4'h5, 3'b010, 2, 1'b0, 32'h0, 1, "post_rst");
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
    req_prot = '0; rsp_ready = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    test_reset();
    test_write_nowait();
    test_read_wait();
    test_slverr();
    test_decerr();
    test_timeout_backpressure();
    test_back_to_back();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
